// File: rtl/timer_pkg.sv
// Shared definitions for the round-robin timer arbiter: FSM state encoding
// and an index-width helper.
package timer_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] COOL = 2'd2;

    // Number of bits needed to index n requesters (minimum 1).
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request bit at or
// after the pointer, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Scan candidates ptr, ptr+1, ... in priority order; first hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            int unsigned  s;
            logic [IW-1:0] c;
            s = 32'(ptr) + i;
            if (s >= N) begin
                s = s - N;
            end
            c = IW'(s);
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = c;
            end
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// Shares one down-counter between N requesters. A granted requester's value
// is loaded, counted to zero, and a one-cycle done pulse returned. A single
// COOL cycle after each ownership lets clients lower req before re-arbitration.
module timer_arbiter
    import timer_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  value,
    output logic [N-1:0]    grant,
    output logic [N-1:0]    done,
    output logic            busy,
    output logic [IW-1:0]   owner
);

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  cnt_q, cnt_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [N-1:0]  done_q, done_d;

    logic          pick_found;
    logic [IW-1:0] pick_idx;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state logic for the FSM, counter, pointer and output registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        done_d  = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    owner_d           = pick_idx;
                    cnt_d             = value[32'(pick_idx) * W +: W];
                    state_d           = RUN;
                end
            end
            RUN: begin
                // Abort wins over expiry when both happen in the same cycle.
                if (!req[owner_q]) begin
                    grant_d = '0;
                    state_d = COOL;
                end else if (cnt_q == '0) begin
                    done_d[owner_q] = 1'b1;
                    grant_d         = '0;
                    state_d         = COOL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            COOL: begin
                ptr_d   = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = (state_q == RUN);
    assign owner = owner_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter (W=8, N=4): fixed vectors with
// hand-computed expected grant/done/busy/owner per cycle.
module tb_timer_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] value;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [1:0]  owner;

    int n_tests = 0;
    int n_fail  = 0;

    timer_arbiter #(
        .W  (8),
        .N  (4),
        .IW (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .value (value),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .owner (owner)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req   = '0;
        value = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req   = '0;
        value = '0;
        tick();
        tick();
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rst_grant got=%b exp=%b", grant, 4'b0000); end
        n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL rst_done got=%b exp=%b", done, 4'b0000); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_tests++; if (owner !== 2'd0) begin n_fail++; $display("FAIL rst_owner got=%0d exp=0", owner); end
        reset = 1'b0;
        tick();
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL idle_grant got=%b exp=%b", grant, 4'b0000); end
    endtask

    // V=5: done 6 cycles after grant, busy high for 6 cycles.
    task automatic test_basic;
        req        = 4'b0001;
        value[7:0] = 8'h05;
        tick();
        n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL basic_grant got=%b exp=%b", grant, 4'b0001); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy0 got=%b exp=1", busy); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k < 6) begin
                n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL basic_early_done k=%0d got=%b exp=%b", k, done, 4'b0000); end
                n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy k=%0d got=%b exp=1", k, busy); end
            end else begin
                n_tests++; if (done !== 4'b0001) begin n_fail++; $display("FAIL basic_done got=%b exp=%b", done, 4'b0001); end
                n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL basic_grant_clr got=%b exp=%b", grant, 4'b0000); end
                n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_clr got=%b exp=0", busy); end
            end
        end
        req = '0;
        tick();
        n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL basic_done_width got=%b exp=%b", done, 4'b0000); end
    endtask

    // V=0 with req held: done on first cycle after grant, re-grant 3 cycles later.
    task automatic test_zero_regrant;
        do_reset();
        req        = 4'b0001;
        value[7:0] = 8'h00;
        tick();
        n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL zero_grant got=%b exp=%b", grant, 4'b0001); end
        tick();
        n_tests++; if (done !== 4'b0001) begin n_fail++; $display("FAIL zero_done got=%b exp=%b", done, 4'b0001); end
        tick();
        n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL zero_cool_done got=%b exp=%b", done, 4'b0000); end
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL zero_cool_grant got=%b exp=%b", grant, 4'b0000); end
        tick();
        n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL zero_regrant got=%b exp=%b", grant, 4'b0001); end
        // Drop req while counter is already 0: abort must win, no done.
        req = '0;
        tick();
        n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL zero_abort_prio got=%b exp=%b", done, 4'b0000); end
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL zero_abort_grant got=%b exp=%b", grant, 4'b0000); end
        tick();
    endtask

    // All four requesting, V=2: grants 0,1,2,3,0 five cycles apart.
    task automatic test_round_robin;
        logic [3:0] eg;
        logic [3:0] ed;
        int         p;
        int         idx;
        do_reset();
        value = {4{8'h02}};
        req   = 4'b1111;
        for (int t = 1; t <= 22; t++) begin
            tick();
            p   = (t - 1) % 5;
            idx = ((t - 1) / 5) % 4;
            eg  = (p <= 2) ? (4'b0001 << idx) : 4'b0000;
            ed  = (p == 3) ? (4'b0001 << idx) : 4'b0000;
            n_tests++; if (grant !== eg) begin n_fail++; $display("FAIL rr_grant t=%0d got=%b exp=%b", t, grant, eg); end
            n_tests++; if (done !== ed) begin n_fail++; $display("FAIL rr_done t=%0d got=%b exp=%b", t, done, ed); end
        end
        req = '0;
        tick();
        tick();
    endtask

    // Drop req2 four cycles after grant: no done, back to IDLE after COOL.
    task automatic test_abort;
        do_reset();
        req          = 4'b0100;
        value[23:16] = 8'h10;
        tick();
        n_tests++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL abort_grant got=%b exp=%b", grant, 4'b0100); end
        n_tests++; if (owner !== 2'd2) begin n_fail++; $display("FAIL abort_owner got=%0d exp=2", owner); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_tests++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL abort_hold k=%0d got=%b exp=%b", k, grant, 4'b0100); end
        end
        req = '0;
        tick();
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL abort_clr got=%b exp=%b", grant, 4'b0000); end
        n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL abort_nodone got=%b exp=%b", done, 4'b0000); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
        tick();
        n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL abort_nodone2 got=%b exp=%b", done, 4'b0000); end
        req        = 4'b0001;
        value[7:0] = 8'h03;
        tick();
        n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL abort_idle got=%b exp=%b", grant, 4'b0001); end
        req = '0;
        tick();
        tick();
    endtask

    // Reset during RUN with counter=8; pointer must return to 0 afterwards.
    task automatic test_reset_mid_run;
        do_reset();
        req          = 4'b0100;
        value[23:16] = 8'h00;
        tick();
        tick();
        req = '0;
        tick();
        req        = 4'b0001;
        value[7:0] = 8'h0A;
        tick();
        tick();
        tick();
        n_tests++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL mid_pre_grant got=%b exp=%b", grant, 4'b0001); end
        reset = 1'b1;
        req   = '0;
        tick();
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL mid_grant got=%b exp=%b", grant, 4'b0000); end
        n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL mid_done got=%b exp=%b", done, 4'b0000); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got=%b exp=0", busy); end
        reset        = 1'b0;
        req          = 4'b1010;
        value[15:8]  = 8'h03;
        value[31:24] = 8'h03;
        tick();
        n_tests++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL mid_ptr_grant got=%b exp=%b", grant, 4'b0010); end
        n_tests++; if (owner !== 2'd1) begin n_fail++; $display("FAIL mid_ptr_owner got=%0d exp=1", owner); end
        req = '0;
        tick();
        tick();
    endtask

    // value1 changes from 7 to 1 while granted: done still at grant+8.
    task automatic test_value_change;
        do_reset();
        req         = 4'b0010;
        value[15:8] = 8'h07;
        tick();
        n_tests++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL vchg_grant got=%b exp=%b", grant, 4'b0010); end
        value[15:8] = 8'h01;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 8) begin
                n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL vchg_early k=%0d got=%b exp=%b", k, done, 4'b0000); end
            end else begin
                n_tests++; if (done !== 4'b0010) begin n_fail++; $display("FAIL vchg_done got=%b exp=%b", done, 4'b0010); end
            end
        end
        req = '0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        value = '0;
        test_reset();
        test_basic();
        test_zero_regrant();
        test_round_robin();
        test_abort();
        test_reset_mid_run();
        test_value_change();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
